// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: state encoding,
// default pattern width and the length clamp helper.
package serial_pattern_gen_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      SHIFT = 3'b001,
      DONE  = 3'b010
   } state_t;

   // Requested lengths above the register width are sent as a full-width pattern
   function automatic int unsigned clampLen(input int unsigned reqLen, input int unsigned maxLen);
      return (reqLen > maxLen) ? maxLen : reqLen;
   endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, left-shift register whose MSB is the serial output bit.
// Clear has priority over load, and load has priority over shift.
module pattern_shift_reg
   import serial_pattern_gen_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] sr_q;

   // Hold the pattern being sent; zeros enter from the right as bits leave the top
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sr_q <= '0;
      end else if (clear_i) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= data_i;
      end else if (shift_i) begin
         sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends a left-justified parallel pattern MSB-first
// on w_o, framed by busy_o/done_o, with w_valid_o qualifying each data bit.
// Optional feature: define SERIAL_PATTERN_GEN_REPEAT_EN to add repeat_i, which
// reloads the captured pattern on the last bit for gapless repetition.
module serial_pattern_gen
   import serial_pattern_gen_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             start_i,
   input  logic [WIDTH-1:0] pattern_i,
   input  logic [CW-1:0]    len_i,
   input  logic             abort_i,
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
   input  logic             repeat_i,
`endif
   output logic             w_o,
   output logic             w_valid_o,
   output logic             busy_o,
   output logic             done_o
);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    clampedLen;
   logic             wValid_q, wValid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             srClear, srLoad, srShift;
   logic [WIDTH-1:0] srData;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
   logic [WIDTH-1:0] shadowPattern_q;
   logic [CW-1:0]    shadowLen_q;
`endif

   // w_o comes straight from the register MSB; the register is cleared whenever
   // the block leaves SHIFT so the line idles at 0 without extra gating.
   pattern_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shiftReg (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .clear_i (srClear),
      .load_i  (srLoad),
      .shift_i (srShift),
      .data_i  (srData),
      .msb_o   (w_o)
   );

   // Decide next state, counter value, next-cycle outputs and shift register controls
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wValid_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      srClear    = 1'b0;
      srLoad     = 1'b0;
      srShift    = 1'b0;
      srData     = pattern_i;
      clampedLen = CW'(clampLen(32'(len_i), unsigned'(WIDTH)));

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               busy_d = 1'b1;
               if (clampedLen == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  srClear = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d  = SHIFT;
                  srLoad   = 1'b1;
                  cnt_d    = clampedLen;
                  wValid_d = 1'b1;
               end
            end
         end

         SHIFT: begin
            if (abort_i) begin
               state_d = IDLE;
               srClear = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == CW'(1)) begin
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
               if (repeat_i) begin
                  srLoad   = 1'b1;
                  srData   = shadowPattern_q;
                  cnt_d    = shadowLen_q;
                  wValid_d = 1'b1;
                  busy_d   = 1'b1;
               end else begin
                  state_d = DONE;
                  srClear = 1'b1;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  done_d  = 1'b1;
               end
`else
               state_d = DONE;
               srClear = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b1;
`endif
            end else begin
               srShift  = 1'b1;
               cnt_d    = cnt_q - CW'(1);
               wValid_d = 1'b1;
               busy_d   = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            srClear = 1'b1;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state, bit counter and registered handshake outputs
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wValid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wValid_q <= wValid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
   // Keep the accepted pattern and length so a repetition can reload them
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         shadowPattern_q <= '0;
         shadowLen_q     <= '0;
      end else if (state_q == IDLE && start_i) begin
         shadowPattern_q <= pattern_i;
         shadowLen_q     <= clampedLen;
      end
   end
`endif

   assign w_valid_o = wValid_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Testbench for serial_pattern_gen: a table of directed transfers with their
// expected serial stream and handshake counts, randomized transfers checked
// cycle by cycle against a behavioural model, plus reset and repeat sequences.
// The repeat sequence is compiled in when SERIAL_PATTERN_GEN_REPEAT_EN is defined.
module tb_serial_pattern_gen;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             Clock = 1'b0;
   logic             Resetn;
   logic             start_i;
   logic [WIDTH-1:0] pattern_i;
   logic [CW-1:0]    len_i;
   logic             abort_i;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
   logic             repeat_i;
`endif
   logic             w_o;
   logic             w_valid_o;
   logic             busy_o;
   logic             done_o;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic [WIDTH-1:0] pattern;
      logic [CW-1:0]    len;
      int               abortAt;
      bit               noise;
      logic [WIDTH-1:0] expSerial;
      int               expValid;
      int               expDone;
      int               expBusy;
   } vector_t;

   vector_t vectors[6];

   // Free-running clock, 10 time units per cycle
   always #5 Clock = ~Clock;

   serial_pattern_gen #(
      .WIDTH (WIDTH)
   ) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .start_i   (start_i),
      .pattern_i (pattern_i),
      .len_i     (len_i),
      .abort_i   (abort_i),
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
      .repeat_i  (repeat_i),
`endif
      .w_o       (w_o),
      .w_valid_o (w_valid_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   // Expected {w, w_valid, busy, done} in cycle c of a transfer started on edge 0
   function automatic logic [3:0] modelOutput(input logic [WIDTH-1:0] pat, input int effLen,
                                              input int abortAt, input int c);
      if (abortAt != 0 && c > abortAt) return 4'b0000;
      if (c >= 1 && c <= effLen) return {pat[WIDTH - c], 3'b110};
      if (c == effLen + 1) return 4'b0011;
      return 4'b0000;
   endfunction

   // Compare all four outputs against the required values
   task automatic checkOutput(input string name, input logic [3:0] expected);
      logic [3:0] actual;
      actual = {w_o, w_valid_o, busy_o, done_o};
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s w/valid/busy/done actual=%b required=%b", name, actual, expected);
      end
   endtask

   // Compare a collected integer summary value
   task automatic checkValue(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Run one transfer from IDLE; checks each cycle against the model and
   // returns the bits seen while w_valid was high plus handshake counts.
   // Called #1 after a rising edge; returns #1 after a rising edge in IDLE.
   task automatic applyStimulus(input logic [WIDTH-1:0] pat, input logic [CW-1:0] len,
                                input int abortAt, input bit noise,
                                output logic [WIDTH-1:0] serial, output int validCnt,
                                output int doneCnt, output int busyCnt);
      int effLen;
      int lastCycle;
      int idx;
      effLen    = (int'(len) > WIDTH) ? WIDTH : int'(len);
      lastCycle = (abortAt != 0) ? abortAt + 1 : effLen + 2;
      serial    = '0;
      validCnt  = 0;
      doneCnt   = 0;
      busyCnt   = 0;
      idx       = 0;
      pattern_i = pat;
      len_i     = len;
      start_i   = 1'b1;
      abort_i   = 1'b0;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
      repeat_i  = 1'b0;
`endif
      @(posedge Clock);
      #1;
      for (int c = 1; c <= lastCycle; c++) begin
         abort_i = (c == abortAt);
         if (noise && c < lastCycle) begin
            start_i   = 1'($urandom);
            pattern_i = WIDTH'($urandom);
            len_i     = CW'($urandom);
         end else begin
            start_i = 1'b0;
         end
         @(negedge Clock);
         checkOutput($sformatf("cycle%0d pat=%h len=%0d abort=%0d", c, pat, len, abortAt),
                     modelOutput(pat, effLen, abortAt, c));
         if (w_valid_o) begin
            if (idx < WIDTH) serial[WIDTH - 1 - idx] = w_o;
            idx++;
            validCnt++;
         end
         if (done_o) doneCnt++;
         if (busy_o) busyCnt++;
         @(posedge Clock);
         #1;
      end
      start_i = 1'b0;
      abort_i = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] serial;
      int validCnt, doneCnt, busyCnt;
      logic [WIDTH-1:0] pat;
      logic [CW-1:0]    len;
      int effLen, abortAt;

      // pattern, len, abortAt, noise, expSerial, expValid, expDone, expBusy
      vectors[0] = '{8'hE0, 4'd3,  0, 1'b0, 8'hE0, 3, 1, 4};
      vectors[1] = '{8'hA5, 4'd8,  0, 1'b1, 8'hA5, 8, 1, 9};
      vectors[2] = '{8'hFF, 4'd0,  0, 1'b1, 8'h00, 0, 1, 1};
      vectors[3] = '{8'h3C, 4'd15, 0, 1'b0, 8'h3C, 8, 1, 9};
      vectors[4] = '{8'hA5, 4'd8,  3, 1'b1, 8'hA0, 3, 0, 3};
      vectors[5] = '{8'h80, 4'd1,  0, 1'b0, 8'h80, 1, 1, 2};

      Resetn    = 1'b0;
      start_i   = 1'b0;
      abort_i   = 1'b0;
      pattern_i = '0;
      len_i     = '0;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
      repeat_i  = 1'b0;
`endif
      #12;
      checkOutput("resetState", 4'b0000);
      @(posedge Clock);
      #1;
      Resetn = 1'b1;
      @(negedge Clock);
      checkOutput("idleAfterReset", 4'b0000);
      @(posedge Clock);
      #1;

      $display("[TB] directed vector table");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vectors[i].pattern, vectors[i].len, vectors[i].abortAt, vectors[i].noise,
                       serial, validCnt, doneCnt, busyCnt);
         checkValue($sformatf("vec%0d serial", i), int'(serial), int'(vectors[i].expSerial));
         checkValue($sformatf("vec%0d validCycles", i), validCnt, vectors[i].expValid);
         checkValue($sformatf("vec%0d donePulses", i), doneCnt, vectors[i].expDone);
         checkValue($sformatf("vec%0d busyCycles", i), busyCnt, vectors[i].expBusy);
      end

      $display("[TB] randomized transfers");
      for (int i = 0; i < 30; i++) begin
         pat     = WIDTH'($urandom);
         len     = CW'($urandom_range(0, 15));
         effLen  = (int'(len) > WIDTH) ? WIDTH : int'(len);
         abortAt = (effLen > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, effLen)) : 0;
         applyStimulus(pat, len, abortAt, 1'($urandom), serial, validCnt, doneCnt, busyCnt);
         checkValue($sformatf("rand%0d donePulses", i), doneCnt, (abortAt == 0) ? 1 : 0);
      end

      $display("[TB] reset during transfer");
      pattern_i = 8'hA5;
      len_i     = 4'd8;
      start_i   = 1'b1;
      @(posedge Clock);
      #1;
      start_i = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      checkOutput("preReset cycle4", modelOutput(8'hA5, 8, 0, 4));
      @(posedge Clock);
      #3;
      Resetn = 1'b0;
      #1;
      checkOutput("asyncReset", 4'b0000);
      @(posedge Clock);
      #1;
      Resetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clock);
         checkOutput($sformatf("stayIdle%0d", c), 4'b0000);
      end
      @(posedge Clock);
      #1;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
      $display("[TB] repeat sequence");
      pattern_i = 8'hC0;
      len_i     = 4'd2;
      start_i   = 1'b1;
      repeat_i  = 1'b1;
      @(posedge Clock);
      #1;
      start_i = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         repeat_i = (c < 6);
         @(negedge Clock);
         checkOutput($sformatf("repeat cycle%0d", c),
                     (c <= 6) ? 4'b1110 : ((c == 7) ? 4'b0011 : 4'b0000));
         @(posedge Clock);
         #1;
      end
      repeat_i = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
